// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised FIFO with count, almost flags, sticky errors; FIFO_FWFT_EN selects first-word-fall-through
module fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    output logic             full,
    output logic             almost_full,
    input  logic             read,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp_inc;
    logic [PW-1:0]    rp_inc;
    logic [CW-1:0]    count_n;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come from registered count only, so acceptance never depends combinationally on the other side.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = write & ~full;
    assign rd_acc = read & ~empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign wp_inc  = (wp == LAST) ? '0 : wp + 1'b1;
    assign rp_inc  = (rp == LAST) ? '0 : rp + 1'b1;
    assign count_n = count + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wp <= wp_inc;
            if (rd_acc) rp <= rp_inc;
            count <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr_err) | (write & full);
            underflow <= (underflow & ~clr_err) | (read & empty);
        end
    end

`ifdef FIFO_FWFT_EN
    // dout tracks the head: a write becomes the head when nothing else remains after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (wr_acc && (count == CW'(rd_acc))) begin
            dout <= din;
        end else if (rd_acc && (count_n != '0)) begin
            dout <= mem[rp_inc];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_acc) begin
            dout <= mem[rp];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param (DEPTH=4 and DEPTH=5 instances)
module tb_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic [2:0] count_a, count_b;
    logic       full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
    logic       full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full_a),
        .almost_full(afull_a), .read(read), .dout(dout_a), .empty(empty_a),
        .almost_empty(aempty_a), .count(count_a), .overflow(ovf_a),
        .underflow(unf_a), .clr_err(clr_err)
    );

    fifo_param #(.WIDTH(8), .DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full_b),
        .almost_full(afull_b), .read(read), .dout(dout_b), .empty(empty_b),
        .almost_empty(aempty_b), .count(count_b), .overflow(ovf_b),
        .underflow(unf_b), .clr_err(clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        din   = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic pop;
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    // Standard mode: data appears after the popping edge; FWFT: data is on dout before the pop.
    task automatic pop_chk(input bit sel, input string tag, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
        check(tag, sel ? dout_b : dout_a, exp);
        pop();
`else
        pop();
        check(tag, sel ? dout_b : dout_a, exp);
`endif
    endtask

    logic [4:0] ae_tab = 5'b00011;
    logic [4:0] af_tab = 5'b11000;

    initial begin
        do_reset();
        check("rst_count", count_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_aempty", aempty_a, 1);
        check("rst_afull", afull_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_unf", unf_a, 0);
        check("rst_dout", dout_a, 0);

        push(8'h11); push(8'h22); push(8'h33);
        check("seq_count3", count_a, 3);
        check("seq_nempty", empty_a, 0);
        pop_chk(0, "seq_d0", 8'h11);
        check("seq_count2", count_a, 2);
        pop_chk(0, "seq_d1", 8'h22);
        pop_chk(0, "seq_d2", 8'h33);
        check("seq_count0", count_a, 0);
        check("seq_empty", empty_a, 1);

        do_reset();
        for (int k = 1; k <= 5; k++) push(8'(k));
        check("d5_full", full_b, 1);
        check("d5_count", count_b, 5);
        push(8'h66);
        check("d5_ovf", ovf_b, 1);
        check("d5_count_ovf", count_b, 5);
        for (int k = 1; k <= 5; k++) pop_chk(1, "d5_data", 8'(k));
        check("d5_empty", empty_b, 1);
        push(8'h77);
        pop_chk(1, "d5_wrap", 8'h77);
        check("d5_empty2", empty_b, 1);

        do_reset();
        for (int i = 0; i <= 4; i++) begin
            check("up_count", count_a, i);
            check("up_aempty", aempty_a, ae_tab[i]);
            check("up_afull", afull_a, af_tab[i]);
            if (i < 4) push(8'(8'hc0 + i));
        end
        check("up_full", full_a, 1);

        din = 8'h99; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        check("wr_full_count", count_a, 3);
        check("wr_full_ovf", ovf_a, 1);
        for (int i = 2; i >= 0; i--) begin
            pop();
            check("dn_count", count_a, i);
            check("dn_aempty", aempty_a, ae_tab[i]);
            check("dn_afull", afull_a, af_tab[i]);
        end

        do_reset();
        din = 8'h42; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        check("wr_empty_count", count_a, 1);
        check("wr_empty_unf", unf_a, 1);
        pop_chk(0, "wr_empty_data", 8'h42);
        clr_err = 1'b1;
        tick();
        check("clr_unf", unf_a, 0);
        read = 1'b1;
        tick();
        read = 1'b0; clr_err = 1'b0;
        check("clr_set_wins", unf_a, 1);

        push(8'h10); push(8'h20);
        check("mid_count", count_a, 2);
        do_reset();
        check("mid_rst_count", count_a, 0);
        check("mid_rst_empty", empty_a, 1);
        check("mid_rst_unf", unf_a, 0);
        check("mid_rst_aempty", aempty_a, 1);
        push(8'ha5);
        pop_chk(0, "mid_a5", 8'ha5);
        check("mid_empty", empty_a, 1);

`ifdef FIFO_FWFT_EN
        do_reset();
        push(8'h5a);
        check("fwft_nempty", empty_a, 0);
        check("fwft_dout", dout_a, 8'h5a);
        pop();
        check("fwft_empty", empty_a, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
